// File: rtl/multi_poscnt_pkg.sv
// Shared types and helpers for multi_poscounter: count-width derivation and the
// position-to-DAC saturating map used by the RTL and its bench model.
package multi_poscnt_pkg;

  localparam int unsigned MaxDacW = 32;
  localparam int unsigned MaxCntW = MaxDacW + 2;

  typedef struct packed {
    logic               vld;
    logic [MaxDacW-1:0] code;
  } dac_map_t;

  function automatic int unsigned cnt_w(input int unsigned dac_w);
    return dac_w + 2;
  endfunction

  // Bits above dac_w+1 of pos must be zero; code bits at and above dac_w come back zero.
  function automatic dac_map_t dac_map(input logic [MaxCntW-1:0] pos, input int unsigned dac_w);
    logic [MaxDacW-1:0] mask;
    logic               m;
    logic               o;
    dac_map_t           r;
    mask   = MaxDacW'((MaxCntW'(1) << dac_w) - MaxCntW'(1));
    m      = |(pos & (MaxCntW'(1) << (dac_w + 1)));
    o      = |(pos & (MaxCntW'(1) << dac_w));
    r.vld  = ~o & ~m;
    r.code = o ? (m ? '0 : mask) : (pos[MaxDacW-1:0] & mask);
    return r;
  endfunction

endpackage

// File: rtl/rate_accum.sv
// Phase-accumulator step generator: adds rate each cycle while go is high and
// reports the carry out as a step request. Cleared whenever go is low.
module rate_accum #(
  parameter int unsigned RATE_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go_i,
  input  logic [RATE_W-1:0] rate_i,
  output logic              carry_o
);

  logic [RATE_W-1:0] acc_q, acc_d;
  logic [RATE_W:0]   sum;

  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, rate_i};
    carry_o = go_i & sum[RATE_W];
    acc_d   = go_i ? sum[RATE_W-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/multi_poscounter.sv
// Multi-channel rate-integrating position counter with preload and saturated DAC output.
// Define MULTI_POSCNT_BIDIR_EN to let dir_i select down-counting.
module multi_poscounter
  import multi_poscnt_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned RATE_W   = 10,
  parameter int unsigned DAC_W    = 10
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CHANNELS-1:0]            go_i,
  input  logic [CHANNELS*RATE_W-1:0]     rate_i,
  input  logic [CHANNELS-1:0]            dir_i,
  input  logic [CHANNELS-1:0]            load_i,
  input  logic [CHANNELS*(DAC_W+2)-1:0]  load_val_i,
  output logic [CHANNELS*(DAC_W+2)-1:0]  pos_o,
  output logic [CHANNELS-1:0]            step_o,
  output logic [CHANNELS*DAC_W-1:0]      dacout_o,
  output logic [CHANNELS-1:0]            dac_vld_o
);

  localparam int unsigned CNT_W = cnt_w(DAC_W);

`ifndef MULTI_POSCNT_BIDIR_EN
  logic unused_dir;
  assign unused_dir = ^dir_i;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic             carry;
    logic             down;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic             step_q, step_d;
    logic [DAC_W-1:0] dac_q, dac_d;
    logic             vld_q, vld_d;
    logic [MaxCntW-1:0] pos_ext;
    dac_map_t         dac_full;
    logic             unused_dac_hi;

    rate_accum #(
      .RATE_W(RATE_W)
    ) u_accum (
      .clk    (clk),
      .reset  (reset),
      .go_i   (go_i[i]),
      .rate_i (rate_i[i*RATE_W +: RATE_W]),
      .carry_o(carry)
    );

`ifdef MULTI_POSCNT_BIDIR_EN
    assign down = dir_i[i];
`else
    assign down = 1'b0;
`endif

    // Load wins over a coincident step request, which is simply dropped.
    always_comb begin
      pos_d  = pos_q;
      step_d = 1'b0;
      if (load_i[i]) begin
        pos_d = load_val_i[i*CNT_W +: CNT_W];
      end else if (carry) begin
        step_d = 1'b1;
        pos_d  = down ? pos_q - CNT_W'(1) : pos_q + CNT_W'(1);
      end
    end

    always_comb begin
      pos_ext              = '0;
      pos_ext[CNT_W-1:0]   = pos_q;
      dac_full             = dac_map(pos_ext, DAC_W);
      dac_d                = dac_full.code[DAC_W-1:0];
      vld_d                = dac_full.vld;
    end

    assign unused_dac_hi = ^dac_full.code[MaxDacW-1:DAC_W];

    always_ff @(posedge clk) begin
      if (reset) begin
        pos_q  <= '0;
        step_q <= 1'b0;
        dac_q  <= '0;
        vld_q  <= 1'b0;
      end else begin
        pos_q  <= pos_d;
        step_q <= step_d;
        dac_q  <= dac_d;
        vld_q  <= vld_d;
      end
    end

    assign pos_o[i*CNT_W +: CNT_W]    = pos_q;
    assign step_o[i]                  = step_q;
    assign dacout_o[i*DAC_W +: DAC_W] = dac_q;
    assign dac_vld_o[i]               = vld_q;
  end

endmodule

// File: tb/tb_multi_poscounter.sv
// Directed self-checking bench for multi_poscounter (4 channels, 10-bit rate/DAC).
module tb_multi_poscounter;

  localparam int Ch   = 4;
  localparam int RW   = 10;
  localparam int DW   = 10;
  localparam int CW   = 12;

  logic             clk = 1'b0;
  logic             reset;
  logic [Ch-1:0]    go;
  logic [Ch*RW-1:0] rate;
  logic [Ch-1:0]    dir;
  logic [Ch-1:0]    load;
  logic [Ch*CW-1:0] load_val;
  logic [Ch*CW-1:0] pos;
  logic [Ch-1:0]    step;
  logic [Ch*DW-1:0] dacout;
  logic [Ch-1:0]    dac_vld;

  int checks = 0;
  int errors = 0;

  multi_poscounter #(
    .CHANNELS(Ch),
    .RATE_W  (RW),
    .DAC_W   (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .go_i      (go),
    .rate_i    (rate),
    .dir_i     (dir),
    .load_i    (load),
    .load_val_i(load_val),
    .pos_o     (pos),
    .step_o    (step),
    .dacout_o  (dacout),
    .dac_vld_o (dac_vld)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] pos_of(input int ch);
    return pos[ch*CW +: CW];
  endfunction

  function automatic logic [DW-1:0] dac_of(input int ch);
    return dacout[ch*DW +: DW];
  endfunction

  initial begin
    reset    = 1'b1;
    go       = 4'b1111;
    rate     = {4{10'h3FF}};
    dir      = '0;
    load     = '0;
    load_val = '0;

    // Reset dominates even with every channel running flat out
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_pos", 64'(pos), 64'(0));
      check("rst_step", 64'(step), 64'(0));
      check("rst_dac", 64'(dacout), 64'(0));
      check("rst_vld", 64'(dac_vld), 64'(0));
    end

    reset = 1'b0;
    go    = '0;
    rate  = '0;
    tick();

    // Ch0 at half rate: step on every second edge
    rate[0 +: RW] = 10'd512;
    go            = 4'b0001;
    for (int j = 1; j <= 20; j++) begin
      tick();
      check("ramp_step", 64'(step[0]), 64'((j % 2) == 0));
      check("ramp_pos", 64'(pos_of(0)), 64'(j / 2));
    end
    check("ramp_dac_lag", 64'(dac_of(0)), 64'(9));
    go = '0;
    tick();
    check("ramp_dac", 64'(dac_of(0)), 64'(10));
    check("ramp_vld", 64'(dac_vld[0]), 64'(1));
    check("ramp_stop_step", 64'(step[0]), 64'(0));
    check("ch1_idle", 64'(pos_of(1)), 64'(0));

    // Positive overflow saturates the DAC
    load[0]           = 1'b1;
    load_val[0 +: CW] = 12'h3FF;
    tick();
    load[0] = 1'b0;
    check("load_3ff", 64'(pos_of(0)), 64'(12'h3FF));
    go = 4'b0001;
    tick();
    tick();
    go = '0;
    check("ovf_pos", 64'(pos_of(0)), 64'(12'h400));
    tick();
    check("ovf_dac", 64'(dac_of(0)), 64'(10'h3FF));
    check("ovf_vld", 64'(dac_vld[0]), 64'(0));

    // Negative region clamps to zero
    load[0]           = 1'b1;
    load_val[0 +: CW] = 12'hC00;
    tick();
    load[0] = 1'b0;
    tick();
    check("neg_pos", 64'(pos_of(0)), 64'(12'hC00));
    check("neg_dac", 64'(dac_of(0)), 64'(0));
    check("neg_vld", 64'(dac_vld[0]), 64'(0));

    // Load coinciding with a carry: load wins, schedule unchanged
    load_val[0 +: CW] = 12'h100;
    go                = 4'b0001;
    tick();
    load[0] = 1'b1;
    tick();
    load[0] = 1'b0;
    check("coll_pos", 64'(pos_of(0)), 64'(12'h100));
    check("coll_step", 64'(step[0]), 64'(0));
    tick();
    check("coll_hold", 64'(pos_of(0)), 64'(12'h100));
    tick();
    check("coll_next", 64'(pos_of(0)), 64'(12'h101));
    check("coll_next_step", 64'(step[0]), 64'(1));
    go = '0;
    tick();

    // Dropping go clears the accumulator
    rate[0 +: RW] = 10'd1;
    go            = 4'b0001;
    for (int j = 0; j < 500; j++) tick();
    go = '0;
    tick();
    check("drop_pos", 64'(pos_of(0)), 64'(12'h101));
    go = 4'b0001;
    for (int j = 0; j < 1023; j++) tick();
    check("restart_pre", 64'(pos_of(0)), 64'(12'h101));
    tick();
    check("restart_pos", 64'(pos_of(0)), 64'(12'h102));
    check("restart_step", 64'(step[0]), 64'(1));
    go = '0;
    tick();

    // Direction input from zero
    load[0]           = 1'b1;
    load_val[0 +: CW] = 12'h000;
    tick();
    load[0]       = 1'b0;
    dir           = 4'b0001;
    rate[0 +: RW] = 10'd512;
    go            = 4'b0001;
    tick();
    tick();
    go = '0;
`ifdef MULTI_POSCNT_BIDIR_EN
    check("dir_pos", 64'(pos_of(0)), 64'(12'hFFF));
    tick();
    check("dir_dac", 64'(dac_of(0)), 64'(0));
    check("dir_vld", 64'(dac_vld[0]), 64'(0));
`else
    check("dir_pos", 64'(pos_of(0)), 64'(1));
    tick();
    check("dir_dac", 64'(dac_of(0)), 64'(1));
    check("dir_vld", 64'(dac_vld[0]), 64'(1));
`endif
    dir = '0;

    // All channels, distinct rates, 4096 cycles
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rate  = {10'd1023, 10'd512, 10'd256, 10'd1};
    go    = 4'b1111;
    for (int j = 0; j < 4096; j++) tick();
    check("multi_ch0", 64'(pos_of(0)), 64'(4));
    check("multi_ch1", 64'(pos_of(1)), 64'(1024));
    check("multi_ch2", 64'(pos_of(2)), 64'(2048));
    check("multi_ch3", 64'(pos_of(3)), 64'(4092));

    // Reset mid-run overrides go and load
    reset    = 1'b1;
    load     = 4'b1111;
    load_val = {4{12'h123}};
    tick();
    check("midrst_pos", 64'(pos), 64'(0));
    check("midrst_step", 64'(step), 64'(0));
    check("midrst_dac", 64'(dacout), 64'(0));
    check("midrst_vld", 64'(dac_vld), 64'(0));
    reset = 1'b0;
    load  = '0;
    go    = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_poscounter.md
# multi_poscounter

Parametrised, multi-channel successor to the single-axis position counter. Each channel integrates a commanded rate into a position count using a phase-accumulator step generator. Counts can be preloaded, and run up, or down when the direction feature is compiled in. Each channel's position is mapped to a saturated DAC code with a validity flag. The block sits between the motion-command registers (rate, direction, load) and the per-axis DAC drivers.

## Interface
- CHANNELS, 4, number of independent axes
- RATE_W, 10, rate word width; step frequency = rate / 2^RATE_W × f_clk
- DAC_W, 10, DAC code width; count width CNT_W = DAC_W+2 (localparam)
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- go  in  CHANNELS  per-channel run enable
- rate  in  CHANNELS×RATE_W  per-channel rate, channel i at [i*RATE_W +: RATE_W]
- dir  in  CHANNELS  1 = count down (only with MULTI_POSCNT_BIDIR_EN)
- load  in  CHANNELS  per-channel load strobe
- load_val  in  CHANNELS×CNT_W  preload position
- pos  out  CHANNELS×CNT_W  current count
- step  out  CHANNELS  registered pulse, high the cycle after a count step
- dacout  out  CHANNELS×DAC_W  DAC code
- dac_vld  out  CHANNELS  DAC code is in range

## Operation
- Reset: acc, pos, step, dacout, dac_vld all 0.
- Step generator, per channel:
  - go=0: acc cleared to 0.
  - go=1: acc ← (acc + rate) mod 2^RATE_W; the carry out is the step request.
  - rate=0 never steps; rate=2^RATE_W−1 steps on 1023 of every 1024 cycles.
- Count priority per channel: reset > load > step.
  - load: pos ← load_val.
  - step: pos ← pos+1, or pos−1 when bidir is enabled and dir=1.
  - Count wraps modulo 2^CNT_W.
- Load does not touch acc. A step request coincident with a load is discarded.
- DAC map, combinational from pos and registered into dacout/dac_vld (M = pos[CNT_W-1], O = pos[CNT_W-2]):
  - O=0: dacout = pos[DAC_W-1:0]; dac_vld = ~M.
  - O=1: dacout = all bits ~M (0x3FF if positive overflow, 0 if negative); dac_vld = 0.
- Channels are fully independent; no shared state.

## Timing
- Edge k: an enabled channel whose accumulator sum carries updates pos at edge k (pos visible after k).
- step is high during cycle k+1. dacout/dac_vld reflect the new pos after edge k+1 (one-cycle latency).
- Load at edge k: pos = load_val after k; dacout updates after k+1.
- go falling: acc = 0 after that edge; no step is generated on that edge.
- Reset mid-operation: all state returns to 0 on the next edge, regardless of go/load.

## Configuration
- MULTI_POSCNT_BIDIR_EN defined: dir selects decrement; underflow 0 → 2^CNT_W−1.
- Not defined: dir is ignored (unconnected internally) and counting is up-only. All other behaviour is identical.

## Structure
- Shared package multi_poscnt_pkg holds:
  - the CNT_W derivation function (DAC_W+2)
  - a dac_map function (pos → {vld, code}) shared with the bench model.
- Sub-module rate_accum: one phase accumulator with inputs go and rate and output carry, instantiated CHANNELS times via generate.
- Top level holds the count registers, load/step priority and DAC registers.

## Test plan
- Reset held 3 cycles with go=1, rate=0x3FF → pos=0, step=0, dacout=0, dac_vld=0 throughout.
- Ch0: rate=512, go=1 for 20 cycles → step every 2nd cycle, pos=10, dacout=10 one cycle later, dac_vld=1. Ch1 with go=0 stays at 0.
- Ch0: load_val=0x3FF, then one step → pos=0x400, dacout=0x3FF, dac_vld=0. load_val=0xC00 → dacout=0x000, dac_vld=0.
- Load coincident with a step request → pos=load_val exactly (no +1), and the next step is still on the accumulator schedule. Dropping go mid-ramp with rate=1 → acc restarts, first step 1024 cycles after go returns.
- MULTI_POSCNT_BIDIR_EN, pos=0, dir=1, rate=512 → pos=0xFFF, dacout=0, dac_vld=0. Without the macro, same stimulus → pos=1.
- All 4 channels at rates 1, 256, 512, 1023 for 4096 cycles → pos = 4, 1024, 2048, 4092 (mod 4096) respectively.
